// File: rtl/addr8s_redundant_sched_if.sv
`default_nettype none
// ---- addr8s_redundant_sched_if : requester, adder and response bundle (rev 1.0) ----
interface addr8s_redundant_sched_if;
   logic       req0_valid;
   logic       req0_ready;
   logic [7:0] req0_a;
   logic [7:0] req0_b;
   logic       req1_valid;
   logic       req1_ready;
   logic [7:0] req1_a;
   logic [7:0] req1_b;
   logic [7:0] add_a;
   logic [7:0] add_b;
   logic [8:0] add_o;
   logic       resp_valid;
   logic       resp_ready;
   logic       resp_id;
   logic [8:0] resp_sum;
   logic       resp_err;
   logic [7:0] err_count;

   // master = clients plus the external adder; slave = the scheduler
   modport master (
      output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, add_o, resp_ready,
      input  req0_ready, req1_ready, add_a, add_b, resp_valid, resp_id, resp_sum,
             resp_err, err_count
   );

   modport slave (
      input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, add_o, resp_ready,
      output req0_ready, req1_ready, add_a, add_b, resp_valid, resp_id, resp_sum,
             resp_err, err_count
   );
endinterface
`default_nettype wire

// File: rtl/addr8s_redundant_sched.sv
`default_nettype none
// ---- addr8s_redundant_sched : time-redundant two-requester scheduler for a shared adder (rev 1.0) ----
module addr8s_redundant_sched #(
   parameter int MAX_RETRY = 2
) (
   input  wire logic                   clk,
   input  wire logic                   rst_n,
   addr8s_redundant_sched_if.slave     bus
);

   localparam logic [2:0] RETRY_LIMIT = 3'(MAX_RETRY);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RUN1 = 3'd1,
      RUN2 = 3'd2,
      CMP  = 3'd3,
      RESP = 3'd4
   } state_t;

   state_t     state;
   state_t     state_next;
   logic [7:0] op_a;
   logic [7:0] op_b;
   logic       op_id;
   logic       last;
   logic [2:0] retry;
   logic [8:0] r1;
   logic [8:0] r2;
   logic [8:0] sum_q;
   logic       err_q;
   logic [7:0] err_cnt;

   logic       grant0;
   logic       grant1;
   logic       accept;
   logic       mismatch;
   logic       can_retry;

   // round robin: with both valid, the requester not served last wins
   assign grant0    = bus.req0_valid & (~bus.req1_valid | last);
   assign grant1    = bus.req1_valid & (~bus.req0_valid | ~last);
   assign accept    = (state == IDLE) & (grant0 | grant1);
   assign mismatch  = (r1 != r2);
   assign can_retry = (retry < RETRY_LIMIT);

   assign bus.resp_id   = op_id;
   assign bus.resp_sum  = sum_q;
   assign bus.resp_err  = err_q;
   assign bus.err_count = err_cnt;

   always_comb begin
      state_next     = state;
      bus.add_a      = 8'd0;
      bus.add_b      = 8'd0;
      bus.req0_ready = 1'b0;
      bus.req1_ready = 1'b0;
      bus.resp_valid = 1'b0;
      case (state)
         IDLE: begin
            bus.req0_ready = grant0;
            bus.req1_ready = grant1;
            if (accept) state_next = RUN1;
         end
         RUN1: begin
            bus.add_a  = op_a;
            bus.add_b  = op_b;
            state_next = RUN2;
         end
         RUN2: begin
            bus.add_a  = op_b;
            bus.add_b  = op_a;
            state_next = CMP;
         end
         CMP: begin
            state_next = (mismatch && can_retry) ? RUN1 : RESP;
         end
         RESP: begin
            bus.resp_valid = 1'b1;
            if (bus.resp_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         op_a    <= 8'd0;
         op_b    <= 8'd0;
         op_id   <= 1'b0;
         last    <= 1'b1;
         retry   <= 3'd0;
         r1      <= 9'd0;
         r2      <= 9'd0;
         sum_q   <= 9'd0;
         err_q   <= 1'b0;
         err_cnt <= 8'd0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (accept) begin
                  op_a  <= grant0 ? bus.req0_a : bus.req1_a;
                  op_b  <= grant0 ? bus.req0_b : bus.req1_b;
                  op_id <= ~grant0;
                  last  <= ~grant0;
                  retry <= 3'd0;
               end
            end
            RUN1: r1 <= bus.add_o;
            RUN2: r2 <= bus.add_o;
            CMP: begin
               if (mismatch && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
               if (mismatch && can_retry) begin
                  retry <= retry + 3'd1;
               end else begin
                  sum_q <= r1;
                  err_q <= mismatch;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_addr8s_redundant_sched.sv
`default_nettype none
// ---- tb_addr8s_redundant_sched : randomized and directed bench with behavioural adder/fault model (rev 1.0) ----
module tb_addr8s_redundant_sched;

   localparam int MAX_RETRY = 2;

   logic clk;
   logic rst_n;
   int   vectors     = 0;
   int   miscompares = 0;

   addr8s_redundant_sched_if bus();

   addr8s_redundant_sched #(.MAX_RETRY(MAX_RETRY)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // external adder: exact signed sum, with optional injected faults
   // mode 1: flip bit 3 on the first swapped presentation of (t_a,t_b)
   // mode 2: clear bit 0 whenever add_a > add_b (signed)
   int         fault_mode = 0;
   logic [7:0] t_a = 8'd0;
   logic [7:0] t_b = 8'd0;
   int         t_base = 0;
   int         r2cnt  = 0;
   logic       tpat;
   logic [8:0] exact;

   assign tpat = (bus.add_a == t_b) && (bus.add_b == t_a) && (bus.add_a != bus.add_b);

   always_comb begin
      exact     = {bus.add_a[7], bus.add_a} + {bus.add_b[7], bus.add_b};
      bus.add_o = exact;
      if (fault_mode == 1 && tpat && r2cnt == t_base)
         bus.add_o = exact ^ 9'h008;
      else if (fault_mode == 2 && $signed(bus.add_a) > $signed(bus.add_b))
         bus.add_o = {exact[8:1], 1'b0};
   end

   always @(posedge clk) if (tpat) r2cnt <= r2cnt + 1;

   // reference: repeat the two orderings until they agree or retries run out
   function automatic void predict(input logic [7:0] a, input logic [7:0] b, input int mode,
                                   output logic [8:0] sum, output logic err,
                                   output int mism, output int attempts);
      int sa, sb, tot;
      logic [8:0] p1, p2;
      bit done;
      sa = int'($signed(a));
      sb = int'($signed(b));
      tot = sa + sb;
      mism = 0; attempts = 0; done = 0; err = 1'b1; sum = 9'd0;
      for (int att = 0; att <= MAX_RETRY; att++) begin
         if (!done) begin
            attempts++;
            p1 = 9'(tot);
            p2 = 9'(tot);
            if (mode == 2 && sa > sb) p1[0] = 1'b0;
            if (mode == 2 && sb > sa) p2[0] = 1'b0;
            if (mode == 1 && att == 0 && sa != sb) p2[3] = ~p2[3];
            sum = p1;
            if (p1 == p2) begin err = 1'b0; done = 1; end
            else mism++;
         end
      end
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      bus.resp_ready = 1'b0;
      fault_mode = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic issue(input bit id, input logic [7:0] a, input logic [7:0] b, output bit ok);
      ok = 1'b0;
      if (id) begin bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; end
      else    begin bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; end
      for (int i = 0; i < 40; i++) begin
         if (!ok) begin
            @(negedge clk); #1;
            if (id ? bus.req1_ready : bus.req0_ready) ok = 1'b1;
         end
      end
      @(posedge clk); #1;
      if (id) bus.req1_valid = 1'b0; else bus.req0_valid = 1'b0;
   endtask

   // returns at the negedge where resp_valid is first seen; lat counts from the handshake edge
   task automatic wait_resp(input int start, output int lat);
      lat = 0;
      for (int i = start + 1; i <= 60; i++) begin
         if (lat == 0) begin
            @(negedge clk);
            if (bus.resp_valid) lat = i;
         end
      end
   endtask

   task automatic test_reset();
      bit ok; int lat;
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.resp_ready = 1'b0;
      bus.req0_a = 8'd0; bus.req0_b = 8'd0; bus.req1_a = 8'd0; bus.req1_b = 8'd0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      vectors++;
      if ({bus.resp_valid, bus.resp_id, bus.resp_sum, bus.resp_err, bus.add_a, bus.add_b,
           bus.err_count, bus.req0_ready, bus.req1_ready} !== 38'd0) begin
         miscompares++;
         $display("FAIL reset_outputs: valid=%b id=%b sum=%h err=%b a=%h b=%h cnt=%0d, required all zero",
                  bus.resp_valid, bus.resp_id, bus.resp_sum, bus.resp_err, bus.add_a, bus.add_b, bus.err_count);
      end
      rst_n = 1'b1;
      bus.req0_valid = 1'b1; bus.req0_a = 8'h7F; bus.req0_b = 8'h7F; bus.resp_ready = 1'b1;
      #1;
      vectors++;
      if (bus.req0_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL first_ready: req0_ready=%b, required 1", bus.req0_ready);
      end
      @(posedge clk); #1 bus.req0_valid = 1'b0;
      wait_resp(0, lat);
      vectors++;
      if (lat !== 4) begin
         miscompares++;
         $display("FAIL reset_latency: got %0d, required 4", lat);
      end
      vectors++;
      if ({bus.resp_sum, bus.resp_id, bus.resp_err, bus.err_count} !== {9'h0FE, 1'b0, 1'b0, 8'd0}) begin
         miscompares++;
         $display("FAIL pos_overflow: sum=%h id=%b err=%b cnt=%0d, required 0fe 0 0 0",
                  bus.resp_sum, bus.resp_id, bus.resp_err, bus.err_count);
      end
      ok = 1'b1;
   endtask

   task automatic test_overflow();
      bit ok; int lat;
      issue(1'b0, 8'h80, 8'h80, ok);
      wait_resp(0, lat);
      vectors++;
      if ({ok, bus.resp_sum} !== {1'b1, 9'h100}) begin
         miscompares++;
         $display("FAIL neg_overflow: accepted=%b sum=%h, required 1 100", ok, bus.resp_sum);
      end
      issue(1'b0, 8'hFF, 8'h01, ok);
      @(negedge clk);
      vectors++;
      if ({bus.add_a, bus.add_b} !== 16'hFF01) begin
         miscompares++;
         $display("FAIL run1_operands: a=%h b=%h, required ff 01", bus.add_a, bus.add_b);
      end
      @(negedge clk);
      vectors++;
      if ({bus.add_a, bus.add_b} !== 16'h01FF) begin
         miscompares++;
         $display("FAIL run2_operands: a=%h b=%h, required 01 ff", bus.add_a, bus.add_b);
      end
      wait_resp(2, lat);
      vectors++;
      if ({lat, bus.resp_sum, bus.add_a, bus.add_b} !== {32'd4, 9'h000, 16'h0000}) begin
         miscompares++;
         $display("FAIL minus1_plus1: lat=%0d sum=%h add=%h/%h, required 4 000 00/00",
                  lat, bus.resp_sum, bus.add_a, bus.add_b);
      end
   endtask

   task automatic test_arbitration();
      int gid[6]; int gt[6]; int grants; int bad;
      int exp_id[6] = '{0, 1, 0, 1, 1, 1};
      do_reset();
      bus.resp_ready = 1'b1;
      bus.req0_a = 8'd10;  bus.req0_b = 8'd20;
      bus.req1_a = 8'hFD;  bus.req1_b = 8'h9C;
      bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
      grants = 0; bad = 0;
      for (int cyc = 0; cyc < 80; cyc++) begin
         if (grants < 6) begin
            @(negedge clk); #1;
            if (bus.req0_ready && bus.req1_ready) bad++;
            if (bus.resp_valid && bus.resp_sum !== (bus.resp_id ? 9'h199 : 9'h01E)) bad++;
            if (bus.req0_ready || bus.req1_ready) begin
               gid[grants] = int'(bus.req1_ready);
               gt[grants]  = cyc;
               grants++;
               if (grants == 4) bus.req0_valid = 1'b0;
            end
         end
      end
      @(posedge clk); #1 bus.req1_valid = 1'b0;
      vectors++;
      if (grants !== 6 || bad !== 0) begin
         miscompares++;
         $display("FAIL arb_run: grants=%0d errors=%0d, required 6 0", grants, bad);
      end
      for (int i = 0; i < 6; i++) begin
         if (i < grants) begin
            vectors++;
            if (gid[i] !== exp_id[i] || (i > 0 && gt[i] - gt[i-1] !== 5)) begin
               miscompares++;
               $display("FAIL arb_grant%0d: id=%0d spacing=%0d, required id %0d spacing 5",
                        i, gid[i], (i > 0) ? gt[i] - gt[i-1] : 5, exp_id[i]);
            end
         end
      end
      wait_resp(0, grants);
      @(posedge clk); #1;
   endtask

   task automatic test_transient();
      bit ok; int lat;
      do_reset();
      bus.resp_ready = 1'b1;
      fault_mode = 1; t_a = 8'h23; t_b = 8'h11; t_base = r2cnt;
      issue(1'b0, 8'h23, 8'h11, ok);
      wait_resp(0, lat);
      vectors++;
      if ({lat, bus.resp_sum, bus.resp_err, bus.err_count} !== {32'd7, 9'h034, 1'b0, 8'd1}) begin
         miscompares++;
         $display("FAIL transient: lat=%0d sum=%h err=%b cnt=%0d, required 7 034 0 1",
                  lat, bus.resp_sum, bus.resp_err, bus.err_count);
      end
      @(posedge clk); #1 fault_mode = 0;
   endtask

   task automatic test_permanent();
      bit ok; int lat;
      do_reset();
      bus.resp_ready = 1'b1;
      fault_mode = 2;
      issue(1'b0, 8'd5, 8'd2, ok);
      wait_resp(0, lat);
      vectors++;
      if ({lat, bus.resp_sum, bus.resp_err, bus.err_count} !== {32'd10, 9'h006, 1'b1, 8'd3}) begin
         miscompares++;
         $display("FAIL permanent: lat=%0d sum=%h err=%b cnt=%0d, required 10 006 1 3",
                  lat, bus.resp_sum, bus.resp_err, bus.err_count);
      end
      @(posedge clk); #1 fault_mode = 0;
   endtask

   task automatic test_backpressure_reset();
      bit ok; int lat; int bad;
      do_reset();
      fault_mode = 2;
      issue(1'b1, 8'd5, 8'd2, ok);
      wait_resp(0, lat);
      bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); #1;
         vectors++;
         if ({bus.resp_valid, bus.resp_id, bus.resp_err, bus.resp_sum, bus.req0_ready, bus.req1_ready}
             !== {1'b1, 1'b1, 1'b1, 9'h006, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL stall_hold%0d: valid=%b id=%b err=%b sum=%h rdy=%b%b, required 1 1 1 006 00",
                     i, bus.resp_valid, bus.resp_id, bus.resp_err, bus.resp_sum, bus.req0_ready, bus.req1_ready);
         end
      end
      vectors++;
      if (bus.err_count !== 8'd3) begin
         miscompares++;
         $display("FAIL stall_errcnt: got %0d, required 3", bus.err_count);
      end
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.resp_ready = 1'b1;
      @(posedge clk); #1 fault_mode = 0;
      issue(1'b0, 8'h33, 8'h44, ok);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk); #1;
      vectors++;
      if ({bus.resp_valid, bus.resp_id, bus.resp_sum, bus.resp_err, bus.add_a, bus.add_b,
           bus.err_count, bus.req0_ready, bus.req1_ready} !== 38'd0) begin
         miscompares++;
         $display("FAIL midop_reset: valid=%b id=%b sum=%h err=%b a=%h b=%h cnt=%0d, required all zero",
                  bus.resp_valid, bus.resp_id, bus.resp_sum, bus.resp_err, bus.add_a, bus.add_b, bus.err_count);
      end
      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus.resp_valid) bad++;
      end
      vectors++;
      if (bad !== 0) begin
         miscompares++;
         $display("FAIL aborted_resp: resp_valid seen %0d cycles, required 0", bad);
      end
   endtask

   task automatic test_saturation();
      bit ok; int lat;
      do_reset();
      bus.resp_ready = 1'b1;
      fault_mode = 2;
      for (int n = 0; n < 86; n++) begin
         issue(1'b0, 8'd5, 8'd2, ok);
         wait_resp(0, lat);
         if (n == 83) begin
            vectors++;
            if (bus.err_count !== 8'd252) begin
               miscompares++;
               $display("FAIL errcnt_252: got %0d, required 252", bus.err_count);
            end
         end
      end
      vectors++;
      if (bus.err_count !== 8'd255) begin
         miscompares++;
         $display("FAIL errcnt_sat: got %0d, required 255", bus.err_count);
      end
      @(posedge clk); #1 fault_mode = 0;
   endtask

   task automatic test_random();
      bit busy; bit last_m; int cnt; int exp_lat; int mism; int attempts; int errc_m;
      bit e0; bit e1; bit eid; logic [8:0] esum; logic eerr; logic [7:0] ga; logic [7:0] gb;
      do_reset();
      busy = 1'b0; last_m = 1'b1; cnt = 0; exp_lat = 0; errc_m = 0;
      eid = 1'b0; esum = 9'd0; eerr = 1'b0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         @(negedge clk);
         bus.req0_valid = 1'($urandom_range(0, 1));
         bus.req1_valid = 1'($urandom_range(0, 1));
         bus.req0_a = 8'($urandom); bus.req0_b = 8'($urandom);
         bus.req1_a = 8'($urandom); bus.req1_b = 8'($urandom);
         bus.resp_ready = ($urandom_range(0, 3) != 0);
         if (!busy) fault_mode = int'($urandom_range(0, 2));
         if (busy) cnt++;
         #1;
         e0 = !busy && bus.req0_valid && (!bus.req1_valid || last_m);
         e1 = !busy && bus.req1_valid && (!bus.req0_valid || !last_m);
         vectors++;
         if ({bus.req0_ready, bus.req1_ready, bus.resp_valid} !== {e0, e1, busy && cnt >= exp_lat}) begin
            miscompares++;
            $display("FAIL rand_ctrl@%0d: rdy=%b%b valid=%b, required %b%b %b",
                     cyc, bus.req0_ready, bus.req1_ready, bus.resp_valid, e0, e1, busy && cnt >= exp_lat);
         end
         if (busy && cnt >= exp_lat) begin
            vectors++;
            if ({bus.resp_id, bus.resp_sum, bus.resp_err, bus.err_count} !== {eid, esum, eerr, 8'(errc_m)}) begin
               miscompares++;
               $display("FAIL rand_resp@%0d: id=%b sum=%h err=%b cnt=%0d, required %b %h %b %0d",
                        cyc, bus.resp_id, bus.resp_sum, bus.resp_err, bus.err_count, eid, esum, eerr, errc_m);
            end
            if (bus.resp_ready) busy = 1'b0;
         end else if (!busy && (e0 || e1)) begin
            eid = e1;
            ga  = e1 ? bus.req1_a : bus.req0_a;
            gb  = e1 ? bus.req1_b : bus.req0_b;
            t_a = ga; t_b = gb; t_base = r2cnt;
            predict(ga, gb, fault_mode, esum, eerr, mism, attempts);
            errc_m  = (errc_m + mism > 255) ? 255 : errc_m + mism;
            exp_lat = 1 + 3 * attempts;
            last_m  = e1;
            busy    = 1'b1;
            cnt     = 0;
         end
      end
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      test_reset();
      test_overflow();
      test_arbitration();
      test_transient();
      test_permanent();
      test_backpressure_reset();
      test_saturation();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "time limit");
   end

endmodule
`default_nettype wire

// File: doc/addr8s_redundant_sched.md
# addr8s_redundant_sched

Time-redundant scheduler that shares one combinational 8-bit signed adder from the fault-resilient adder family between two requesters. Each operation runs twice on the adder, the second time with operands swapped, and the two 9-bit results are compared. Mismatches are retried a bounded number of times, then reported as an error. The block sits between client logic and an external adder instance whose O[8:0] output is fed back to this block.

## Interface
- MAX_RETRY, 2, number of re-executions allowed after a compare mismatch (range 0..7)
- clk  in  1  single clock, all state rising-edge
- rst_n  in  1  reset; synchronous and active-low
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a, req0_b  in  8 each  requester 0 signed operands
- req1_valid, req1_ready, req1_a, req1_b  same as requester 0, for requester 1
- add_a, add_b  out  8 each  operands driven to the external adder
- add_o  in  9  external adder result, signed A+B, combinational from add_a/add_b
- resp_valid  out  1  result available
- resp_ready  in  1  consumer takes result
- resp_id  out  1  requester index of the result
- resp_sum  out  9  signed 9-bit sum
- resp_err  out  1  redundancy check failed after all retries
- err_count  out  8  saturating count of compare mismatches since reset

## Operation
- States: IDLE, RUN1, RUN2, CMP, RESP.
- IDLE, arbitration:
  - Round-robin pointer `last` resets to 1, so requester 0 wins first.
  - Only one valid: grant it.
  - Both valid: grant the requester other than `last`.
  - req*_ready = (state==IDLE) & grant. At most one ready is high per cycle.
  - Handshake is valid & ready. On handshake: latch A, B and id; set `last` = id; clear retry count; go to RUN1.
- RUN1: add_a=A, add_b=B. Register add_o into r1 at the end of the cycle. Go to RUN2.
- RUN2: add_a=B, add_b=A. Register add_o into r2. Go to CMP.
- CMP:
  - r1==r2: go to RESP with resp_sum=r1, resp_err=0.
  - r1!=r2: increment err_count, saturating at 255.
    - retry<MAX_RETRY: increment retry, go to RUN1.
    - Otherwise: go to RESP with resp_sum=r1, resp_err=1.
- RESP:
  - resp_valid=1. resp_id, resp_sum and resp_err are held stable until resp_ready.
  - On resp_valid & resp_ready: go to IDLE.
  - No new request is accepted while in RESP.
- add_a/add_b are 0 in IDLE, CMP and RESP.
- Arithmetic: the block never computes the sum itself. resp_sum is the adder's 9-bit two's-complement result, for example 127+127=9'h0FE and -128+-128=9'h100.
- Request inputs are ignored outside IDLE. Operands are sampled only on handshake.

## Timing
- Reset, with rst_n low at a rising edge:
  - State goes to IDLE.
  - resp_valid, resp_id, resp_sum, resp_err, add_a, add_b and err_count all go to 0.
  - r1, r2 and retry go to 0; `last` goes to 1.
  - Reset mid-operation aborts the operation. No response is produced, and the aborted request is not re-accepted unless its requester is still valid after reset.
- req*_ready is high only while in IDLE.
- Handshake at edge k: RUN1 runs in cycle k+1, RUN2 in k+2, CMP in k+3, and resp_valid rises in k+4.
- Each retry adds 3 cycles. Worst case, resp_valid rises at k+4+3·MAX_RETRY.
- Minimum spacing between accepts is 5 cycles, when resp_ready is held high.
- resp_ready low stalls in RESP indefinitely with outputs held.
- err_count updates at the CMP edge and stays at 255 once reached.

## Test plan
- Reset, fault-free adder model: with req0_valid=1, A=8'h7F, B=8'h7F, expect req0_ready at the first IDLE cycle. Expect resp_valid 4 cycles after the handshake with resp_sum=9'h0FE, resp_id=0, resp_err=0, err_count=0.
- Negative overflow: A=8'h80, B=8'h80 gives resp_sum=9'h100. A=8'hFF, B=8'h01 gives resp_sum=9'h000.
- Arbitration: hold req0_valid and req1_valid high with resp_ready=1. Expect grants 0,1,0,1 and accepts spaced 5 cycles apart. With only req1 valid, expect back-to-back grants to 1.
- Transient fault: the adder model flips add_o[3] on the first RUN2 only. Expect one retry, resp_valid at 7 cycles after the handshake, resp_err=0, correct sum, err_count=1.
- Permanent order-dependent fault: with MAX_RETRY=2, the model forces bit 0 when add_a>add_b, with A=5, B=2. Expect 3 mismatches, resp_valid at 10 cycles, resp_err=1, resp_sum=r1 from the last RUN1, err_count=3.
- Backpressure and reset:
  - Hold resp_ready low for 6 cycles. Expect resp outputs stable and req*_ready low throughout.
  - Then assert rst_n low during a later RUN2. Expect all outputs 0 the next cycle, no response for that operation, and err_count=0.
